// File: rtl/spi_pkg.sv
// Shared SPI peripheral types and constants.
// Frame layout, register map addresses and field widths.
package spi_pkg;

  localparam int FRAME_BITS = 16;
  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;
  localparam int CNT_W      = 5;

  localparam logic [CNT_W-1:0] CNT_MAX = 5'd17;

  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_PWM_DUTY  = 7'h04;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } spi_frame_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop input synchronizer with rise/fall pulses.
// Ports: clk, rst_n (sync, active-low), d_i async in,
// q_o synced level, rise_o/fall_o one-cycle pulses.
module spi_sync_edge #(
  parameter int   STAGES = 2,
  parameter logic IDLE   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {STAGES{IDLE}};
      prev_q <= IDLE;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 write-register peripheral feeding the PWM stage.
// Ports: clk, rst_n (sync, active-low), sclk/copi/ncs async
// SPI pins, cipo readback out, five 8-bit control registers.
// Optional macro SPI_READBACK_EN adds read frames on cipo.
module spi_peripheral
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cipo,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle
);

  localparam logic [ADDR_W-1:0] NREG = ADDR_W'(NUM_REGS);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic ncs_s, ncs_rise, ncs_fall;
  logic copi_s, copi_rise, copi_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE(1'b0)) u_sclk (
    .clk(clk), .rst_n(rst_n), .d_i(sclk),
    .q_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE(1'b1)) u_ncs (
    .clk(clk), .rst_n(rst_n), .d_i(ncs),
    .q_o(ncs_s), .rise_o(ncs_rise), .fall_o(ncs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE(1'b0)) u_copi (
    .clk(clk), .rst_n(rst_n), .d_i(copi),
    .q_o(copi_s), .rise_o(copi_rise), .fall_o(copi_fall)
  );

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic                  commit_q, commit_d;
  logic [DATA_W-1:0]     regs_q [NUM_REGS];
  logic [DATA_W-1:0]     regs_d [NUM_REGS];
  spi_frame_t            frm;

  assign frm = shift_q;

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (ncs_fall) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (sclk_rise && !ncs_s) begin
      shift_d = {shift_q[FRAME_BITS-2:0], copi_s};
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 5'd1;
    end
  end

  // Commit decision is registered; the write lands one
  // cycle later while the shift register is still frozen.
  always_comb begin
    commit_d = ncs_rise
             && (cnt_q == CNT_W'(FRAME_BITS))
             && frm.rw
             && (frm.addr < NREG);
  end

  always_comb begin
    regs_d = regs_q;
    if (commit_q) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (frm.addr == ADDR_W'(i)) regs_d[i] = frm.data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      shift_q  <= '0;
      commit_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      commit_q <= commit_d;
      regs_q   <= regs_d;
    end
  end

  assign en_reg_out_7_0  = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0  = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle  = regs_q[4];

`ifdef SPI_READBACK_EN
  logic [DATA_W-1:0] tx_q, tx_d, rd_sel;
  logic [ADDR_W-1:0] rd_addr;

  assign rd_addr = shift_d[ADDR_W-1:0];

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == ADDR_W'(i)) rd_sel = regs_q[i];
    end
  end

  // Load after the 8th bit; the first fall after the load
  // is skipped so the master sees bit 7 on the next rise.
  always_comb begin
    tx_d = tx_q;
    if (ncs_rise || ncs_fall) begin
      tx_d = '0;
    end else if (sclk_rise && !ncs_s
                 && cnt_q == 5'd7 && !shift_d[7]) begin
      tx_d = rd_sel;
    end else if (sclk_fall && !ncs_s && cnt_q >= 5'd9) begin
      tx_d = {tx_q[DATA_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) tx_q <= '0;
    else        tx_q <= tx_d;
  end

  assign cipo = tx_q[DATA_W-1];

  logic unused_sink;
  assign unused_sink = ^{copi_rise, copi_fall, sclk_lvl};
`else
  assign cipo = 1'b0;

  logic unused_sink;
  assign unused_sink = ^{copi_rise, copi_fall, sclk_lvl,
                         sclk_fall};
`endif

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral.
// Drives SPI frames at clk/10 and checks the register file.
module tb_spi_peripheral;

  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0;
  logic copi = 1'b0;
  logic ncs = 1'b1;
  logic cipo;
  logic [7:0] out_lo, out_hi, pwm_lo, pwm_hi, duty;
  logic [39:0] regs_w;
  logic [39:0] cur;
  logic [15:0] rx;
  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  spi_peripheral #(.SYNC_STAGES(SYNC), .NUM_REGS(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .sclk(sclk), .copi(copi), .ncs(ncs), .cipo(cipo),
    .en_reg_out_7_0(out_lo), .en_reg_out_15_8(out_hi),
    .en_reg_pwm_7_0(pwm_lo), .en_reg_pwm_15_8(pwm_hi),
    .pwm_duty_cycle(duty)
  );

  assign regs_w = {duty, pwm_hi, pwm_lo, out_hi, out_lo};

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    ncs = 1'b0;
    clks(5);
  endtask

  task automatic shift_bits(input logic [31:0] d, input int n,
                            input bit cap);
    for (int i = n - 1; i >= 0; i--) begin
      copi = d[i];
      clks(5);
      if (cap) rx = {rx[14:0], cipo};
      sclk = 1'b1;
      clks(5);
      sclk = 1'b0;
    end
  endtask

  task automatic frame_chk(input string name,
                           input logic [31:0] d, input int n,
                           input logic [39:0] exp, input int gap);
    cs_low();
    shift_bits(d, n, 1'b0);
    clks(5);
    ncs = 1'b1;
    repeat (SYNC + 1) @(posedge clk);
    #1;
    checks++;
    if (regs_w !== cur)
      $display("FAIL %s_early regs=%h required=%h",
               name, regs_w, cur);
    else passed++;
    @(posedge clk);
    #1;
    checks++;
    if (regs_w !== exp)
      $display("FAIL %s regs=%h required=%h", name, regs_w, exp);
    else passed++;
    cur = exp;
    @(negedge clk);
    clks(gap);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clks(5);
    rst_n = 1'b1;
    clks(1);
    checks++;
    if (out_lo !== 8'h00)
      $display("FAIL rst_out_lo got=%h required=00", out_lo);
    else passed++;
    checks++;
    if (out_hi !== 8'h00)
      $display("FAIL rst_out_hi got=%h required=00", out_hi);
    else passed++;
    checks++;
    if (pwm_lo !== 8'h00)
      $display("FAIL rst_pwm_lo got=%h required=00", pwm_lo);
    else passed++;
    checks++;
    if (pwm_hi !== 8'h00)
      $display("FAIL rst_pwm_hi got=%h required=00", pwm_hi);
    else passed++;
    checks++;
    if (duty !== 8'h00)
      $display("FAIL rst_duty got=%h required=00", duty);
    else passed++;
    checks++;
    if (cipo !== 1'b0)
      $display("FAIL rst_cipo got=%b required=0", cipo);
    else passed++;
    cur = 40'h0;
    clks(4);
  endtask

  task automatic test_writes();
    frame_chk("wr0", 32'h80F0, 16, 40'h00_00_00_00_F0, 4);
    frame_chk("wr1", 32'h81CC, 16, 40'h00_00_00_CC_F0, 4);
    frame_chk("wr2", 32'h82FF, 16, 40'h00_00_FF_CC_F0, 4);
    frame_chk("wr3", 32'h8355, 16, 40'h00_55_FF_CC_F0, 4);
    frame_chk("wr4", 32'h8480, 16, 40'h80_55_FF_CC_F0, 4);
  endtask

  task automatic test_discards();
    frame_chk("bad_addr", 32'h8A12, 16, 40'h80_55_FF_CC_F0, 4);
    frame_chk("read", 32'h00AA, 16, 40'h80_55_FF_CC_F0, 4);
    frame_chk("short", 32'h4008, 15, 40'h80_55_FF_CC_F0, 4);
    frame_chk("long", 32'h18033, 17, 40'h80_55_FF_CC_F0, 4);
  endtask

  task automatic test_mid_reset();
    cs_low();
    shift_bits(32'h213, 10, 1'b0);
    rst_n = 1'b0;
    clks(2);
    rst_n = 1'b1;
    shift_bits(32'h3F, 6, 1'b0);
    clks(5);
    ncs = 1'b1;
    clks(8);
    checks++;
    if (regs_w !== 40'h0)
      $display("FAIL mid_reset regs=%h required=%h",
               regs_w, 40'h0);
    else passed++;
    cur = 40'h0;
    frame_chk("after_rst", 32'h8410, 16, 40'h10_00_00_00_00, 4);
  endtask

  task automatic test_back_to_back();
    frame_chk("b2b_a", 32'h8001, 16, 40'h10_00_00_00_01, 0);
    frame_chk("b2b_b", 32'h8002, 16, 40'h10_00_00_00_02, 4);
  endtask

  task automatic test_readback();
    logic [15:0] exp_rx;
`ifdef SPI_READBACK_EN
    exp_rx = 16'h00A5;
`else
    exp_rx = 16'h0000;
`endif
    frame_chk("rb_wr", 32'h84A5, 16, 40'hA5_00_00_00_02, 4);
    cs_low();
    rx = '0;
    shift_bits(32'h0400, 16, 1'b1);
    clks(5);
    ncs = 1'b1;
    clks(6);
    checks++;
    if (rx !== exp_rx)
      $display("FAIL rb_cipo got=%h required=%h", rx, exp_rx);
    else passed++;
    checks++;
    if (cipo !== 1'b0)
      $display("FAIL rb_cipo_idle got=%b required=0", cipo);
    else passed++;
    checks++;
    if (regs_w !== 40'hA5_00_00_00_02)
      $display("FAIL rb_regs regs=%h required=%h",
               regs_w, 40'hA5_00_00_00_02);
    else passed++;
  endtask

  initial begin
    cur = '0;
    rx = '0;
    test_reset();
    test_writes();
    test_discards();
    test_mid_reset();
    test_back_to_back();
    test_readback();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/spi_peripheral.md
# spi_peripheral

SPI mode-0 register-write peripheral inside `tt_um_uwasic_onboarding_eliot_tong`. It sits between the chip pins (`ui_in` SCLK/COPI/nCS) and the PWM stage. It receives 16-bit frames, decodes write commands and holds the five control registers that the PWM stage consumes. The SPI inputs are asynchronous to `clk` and are resynchronised internally.

## Interface
- `SYNC_STAGES`, 2: synchronizer flop depth per SPI input (≥2).
- `NUM_REGS`, 5: number of implemented registers, addresses 0x00..NUM_REGS-1.
- `clk`  in  1  system clock (10 MHz nominal).
- `rst_n`  in  1  reset; **synchronous, active-low**, sampled on `clk` rising edge.
- `sclk`  in  1  SPI clock, async.
- `copi`  in  1  SPI data in, async.
- `ncs`  in  1  SPI chip select, active-low, async.
- `cipo`  out  1  SPI data out (readback only; see Configuration).
- `en_reg_out_7_0`  out  8  reg 0x00, output enables [7:0].
- `en_reg_out_15_8`  out  8  reg 0x01, output enables [15:8].
- `en_reg_pwm_7_0`  out  8  reg 0x02, PWM enables [7:0].
- `en_reg_pwm_15_8`  out  8  reg 0x03, PWM enables [15:8].
- `pwm_duty_cycle`  out  8  reg 0x04, duty (0x00 = 0 %, 0xFF = 100 %).

## Operation
- Reset: all five registers = 0x00, `cipo` = 0, bit counter = 0, shift register = 0, synchronizer flops = idle (`sclk` 0, `ncs` 1, `copi` 0).
- Frame: 16 bits MSB first. Bit 15 is R/W̄ (1 = write). Bits 14:8 are the address. Bits 7:0 are the data.
- Sampling: `copi` is sampled on the synchronised `sclk` rising edge, only while synchronised `ncs` = 0. The sample shifts into a 16-bit shift register, and the bit counter increments, saturating at 17.
- Synchronised `ncs` falling edge clears the counter and the shift register.
- Synchronised `ncs` rising edge is the commit point. A frame commits only when all of these hold:
  - counter == 16,
  - bit 15 == 1,
  - address < NUM_REGS.
- On commit, the addressed register takes bits 7:0. All other registers hold.
- Discard cases (no register change):
  - counter ≠ 16 (short or long frame),
  - read command,
  - address ≥ NUM_REGS.
- `sclk` edges while `ncs` high: ignored.
- `rst_n` low mid-frame: frame lost, registers cleared. The next frame needs a fresh `ncs` falling edge.
- A simultaneous commit and `rst_n` low: reset wins.

## Timing
- Input synchronizer: SYNC_STAGES flops, plus one flop for edge detection.
- Edge latency: pin edge to detected edge = SYNC_STAGES+1 `clk` cycles.
- Register update latency: visible on the output SYNC_STAGES+2 `clk` cycles after the `ncs` pin rises.
- SCLK limits:
  - SCLK high and low times each ≥ 4 `clk` periods (SCLK ≤ clk/8).
  - `copi` stable from 1 `clk` before to SYNC_STAGES+1 `clk` after the SCLK rising edge.
- nCS timing: ≥ 4 `clk` periods between nCS falling and the first SCLK rise, between the last SCLK fall and nCS rising, and between frames.
- Outputs are registered and glitch-free. They change only on commit or reset.

## Configuration
- `SPI_READBACK_EN` defined: read frames are supported.
  - Trigger: after the 8th sampled bit with bit 15 = 0.
  - Load: the shift-out register takes the addressed register, or 0x00 for an invalid address.
  - `cipo` drives data bit 7 from then on and shifts on each synchronised `sclk` falling edge through bits 6..0.
  - `cipo` returns to 0 on `ncs` rising. Reads never modify registers.
- `SPI_READBACK_EN` undefined: `cipo` is tied to 0 and no readback logic exists. Read frames are discarded as above.

## Structure
- Package `spi_pkg`:
  - address localparams `ADDR_EN_OUT_LO`=0x00 … `ADDR_PWM_DUTY`=0x04,
  - `FRAME_BITS`=16,
  - `ADDR_W`=7, `DATA_W`=8,
  - typedef `spi_frame_t` (packed struct: `rw`, `addr`, `data`).
- Sub-module `spi_sync_edge`: SYNC_STAGES-deep synchronizer with rise/fall pulse outputs, synchronous active-low reset with a parameterised idle value. Instantiated three times (`sclk`, `ncs`, `copi`; pulses unused for `copi`).

## Test plan
- Reset: hold `rst_n` = 0 for 5 cycles -> all registers 0x00, `cipo` = 0.
- Write each address with SCLK = clk/10, in order:
  - 0x80F0 -> `en_reg_out_7_0` = 0xF0,
  - 0x81CC -> `en_reg_out_15_8` = 0xCC,
  - 0x82FF -> `en_reg_pwm_7_0` = 0xFF,
  - 0x8355 -> `en_reg_pwm_15_8` = 0x55,
  - 0x8480 -> `pwm_duty_cycle` = 0x80.
  - Each update appears exactly SYNC_STAGES+2 cycles after `ncs` rises.
- Discards, starting with reg 0x00 = 0xF0:
  - invalid address 0x8A12 -> all registers unchanged,
  - read frame 0x00AA -> unchanged,
  - 15-bit frame -> unchanged,
  - 17-bit frame -> unchanged.
- Mid-frame reset: after 10 bits of 0x84FF, pulse `rst_n` low 2 cycles, then complete the frame -> `pwm_duty_cycle` = 0x00. A following full 0x8410 -> 0x10.
- Back-to-back: 0x8001 then 0x8002 with the minimum 4-cycle nCS gap -> `en_reg_out_7_0` = 0x01, then 0x02.
- Readback (with `SPI_READBACK_EN`): write 0x84A5, then read frame 0x0400 -> `cipo` bits 10100101 on the data-phase SCLK rising edges, `pwm_duty_cycle` stays 0xA5. Without the macro -> `cipo` = 0 throughout.
